// File: rtl/dx_stage_elastic_pkg.sv
// Shared definitions for the decode/execute elastic stage: default widths,
// slot and forwarding-source layouts, and the hard-wired zero register.
package dx_stage_elastic_pkg;

    localparam int DX_DW      = 32;
    localparam int DX_AW      = 5;
    localparam int DX_PC_W    = 32;
    localparam int DX_CTRL_W  = 16;
    localparam int DX_NUM_SRC = 2;
    localparam int DX_NUM_FWD = 2;

    // Register 0 reads as zero and is never a forwarding target.
    localparam int ZERO_REG = 0;

    typedef struct packed {
        logic                                   valid;
        logic [DX_CTRL_W-1:0]                   ctrl;
        logic [DX_PC_W-1:0]                     pc;
        logic [DX_DW-1:0]                       imm;
        logic [DX_NUM_SRC-1:0][DX_AW-1:0]       src_addr;
        logic [DX_NUM_SRC-1:0][DX_DW-1:0]       src_data;
        logic [DX_AW-1:0]                       dst_addr;
    } dx_slot_t;

    typedef struct packed {
        logic             valid;
        logic [DX_AW-1:0] addr;
        logic [DX_DW-1:0] data;
    } fwd_src_t;

endpackage

// File: rtl/dx_fwd_mux.sv
// Per-operand forwarding priority matcher; lowest index (youngest stage) wins.
// Latency: combinational. Backpressure: none, pure function of its inputs.
// Operands addressing the zero register always keep their current data.
module dx_fwd_mux
    import dx_stage_elastic_pkg::*;
#(
    parameter int DW      = DX_DW,
    parameter int AW      = DX_AW,
    parameter int NUM_FWD = DX_NUM_FWD
) (
    input  logic [AW-1:0]         src_addr,
    input  logic [DW-1:0]         cur_data,
    input  logic [NUM_FWD-1:0]    fwd_valid,
    input  logic [NUM_FWD*AW-1:0] fwd_addr,
    input  logic [NUM_FWD*DW-1:0] fwd_data,
    output logic [DW-1:0]         data
);

    // Scanning oldest to youngest lets the youngest match overwrite last.
    always_comb begin
        data = cur_data;
        if (src_addr != AW'(ZERO_REG)) begin
            for (int j = NUM_FWD - 1; j >= 0; j--) begin
                if (fwd_valid[j] && (fwd_addr[j*AW +: AW] == src_addr))
                    data = fwd_data[j*DW +: DW];
            end
        end
    end

endmodule

// File: rtl/dx_stage_elastic.sv
// Decode->execute elastic register with main+skid slots and operand forwarding.
// Latency: 1 cycle, 1 entry/cycle. Backpressure: valid/ready, skid absorbs one stalled entry.
// Optional DX_STAGE_PERF_EN adds saturating stall_cnt / bubble_cnt counters.
module dx_stage_elastic
    import dx_stage_elastic_pkg::*;
#(
    parameter int DW      = DX_DW,
    parameter int AW      = DX_AW,
    parameter int PC_W    = DX_PC_W,
    parameter int CTRL_W  = DX_CTRL_W,
    parameter int NUM_SRC = DX_NUM_SRC,
    parameter int NUM_FWD = DX_NUM_FWD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  bubble,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_W-1:0]     in_ctrl,
    input  logic [PC_W-1:0]       in_pc,
    input  logic [DW-1:0]         in_imm,
    input  logic [NUM_SRC*AW-1:0] in_src_addr,
    input  logic [NUM_SRC*DW-1:0] in_src_data,
    input  logic [AW-1:0]         in_dst_addr,
    input  logic [NUM_FWD-1:0]    fwd_valid,
    input  logic [NUM_FWD*AW-1:0] fwd_addr,
    input  logic [NUM_FWD*DW-1:0] fwd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_W-1:0]     out_ctrl,
    output logic [PC_W-1:0]       out_pc,
    output logic [DW-1:0]         out_imm,
    output logic [NUM_SRC*AW-1:0] out_src_addr,
    output logic [NUM_SRC*DW-1:0] out_src_data,
    output logic [AW-1:0]         out_dst_addr
`ifdef DX_STAGE_PERF_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           bubble_cnt
`endif
);

    typedef struct packed {
        logic                  valid;
        logic [CTRL_W-1:0]     ctrl;
        logic [PC_W-1:0]       pc;
        logic [DW-1:0]         imm;
        logic [NUM_SRC*AW-1:0] src_addr;
        logic [NUM_SRC*DW-1:0] src_data;
        logic [AW-1:0]         dst_addr;
    } slot_t;

    slot_t main_q, skid_q, in_slot, main_pre, skid_pre;
    logic [NUM_SRC*DW-1:0] main_fwd, skid_fwd;
    logic accept, advance;

    assign in_ready = !skid_q.valid && !bubble;
    assign accept   = in_valid && in_ready;
    assign advance  = !main_q.valid || out_ready;

    always_comb begin
        in_slot.valid    = 1'b1;
        in_slot.ctrl     = in_ctrl;
        in_slot.pc       = in_pc;
        in_slot.imm      = in_imm;
        in_slot.src_addr = in_src_addr;
        in_slot.src_data = in_src_data;
        in_slot.dst_addr = in_dst_addr;
    end

    // Next-state selection before forwarding; payload of an invalid slot is don't-care.
    always_comb begin
        main_pre = main_q;
        skid_pre = skid_q;
        if (advance) begin
            main_pre       = skid_q.valid ? skid_q : in_slot;
            main_pre.valid = skid_q.valid || accept;
            skid_pre.valid = 1'b0;
        end else if (accept) begin
            skid_pre = in_slot;
        end
        if (flush) begin
            main_pre.valid = 1'b0;
            skid_pre.valid = 1'b0;
        end
    end

    // Forwarding is applied to whatever each slot will hold next, so held
    // entries are refreshed every cycle and captures are forwarded on entry.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_op
        dx_fwd_mux #(.DW(DW), .AW(AW), .NUM_FWD(NUM_FWD)) u_main_fwd (
            .src_addr  (main_pre.src_addr[i*AW +: AW]),
            .cur_data  (main_pre.src_data[i*DW +: DW]),
            .fwd_valid (fwd_valid),
            .fwd_addr  (fwd_addr),
            .fwd_data  (fwd_data),
            .data      (main_fwd[i*DW +: DW])
        );
        dx_fwd_mux #(.DW(DW), .AW(AW), .NUM_FWD(NUM_FWD)) u_skid_fwd (
            .src_addr  (skid_pre.src_addr[i*AW +: AW]),
            .cur_data  (skid_pre.src_data[i*DW +: DW]),
            .fwd_valid (fwd_valid),
            .fwd_addr  (fwd_addr),
            .fwd_data  (fwd_data),
            .data      (skid_fwd[i*DW +: DW])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q          <= main_pre;
            main_q.src_data <= main_fwd;
            skid_q          <= skid_pre;
            skid_q.src_data <= skid_fwd;
        end
    end

    assign out_valid    = main_q.valid;
    assign out_ctrl     = main_q.valid ? main_q.ctrl     : '0;
    assign out_pc       = main_q.valid ? main_q.pc       : '0;
    assign out_imm      = main_q.valid ? main_q.imm      : '0;
    assign out_src_addr = main_q.valid ? main_q.src_addr : '0;
    assign out_src_data = main_q.valid ? main_q.src_data : '0;
    assign out_dst_addr = main_q.valid ? main_q.dst_addr : '0;

`ifdef DX_STAGE_PERF_EN
    // A bubble with an empty skid is exactly the case where main loads invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (main_q.valid && !out_ready && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 32'd1;
            if (advance && !skid_q.valid && bubble && !flush && (bubble_cnt != '1))
                bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dx_stage_elastic.sv
// Randomized + directed bench for dx_stage_elastic against a queue-based model
// of the stage (up to two in-order entries, head drives the outputs).
module tb_dx_stage_elastic;

    logic        clk, rst_n, flush, bubble, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_ctrl, out_ctrl;
    logic [31:0] in_pc, in_imm, out_pc, out_imm;
    logic [9:0]  in_src_addr, out_src_addr, fwd_addr;
    logic [63:0] in_src_data, out_src_data, fwd_data;
    logic [4:0]  in_dst_addr, out_dst_addr;
    logic [1:0]  fwd_valid;

    dx_stage_elastic dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bubble(bubble),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_pc(in_pc),
        .in_imm(in_imm), .in_src_addr(in_src_addr), .in_src_data(in_src_data),
        .in_dst_addr(in_dst_addr), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
        .fwd_data(fwd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_pc(out_pc), .out_imm(out_imm),
        .out_src_addr(out_src_addr), .out_src_data(out_src_data),
        .out_dst_addr(out_dst_addr)
    );

    typedef struct packed {
        logic [15:0]      ctrl;
        logic [31:0]      pc;
        logic [31:0]      imm;
        logic [1:0][4:0]  a;
        logic [1:0][31:0] d;
        logic [4:0]       dst;
    } ent_t;

    ent_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] d);
        for (int j = 0; j < 2; j++)
            if (fwd_valid[j] && fwd_addr[j*5 +: 5] == a && a != 5'd0)
                return fwd_data[j*32 +: 32];
        return d;
    endfunction

    function automatic void model_step();
        ent_t e;
        bit acc;
        acc = in_valid && (q.size() < 2) && !bubble;
        if (flush) begin
            q.delete();
            return;
        end
        if (q.size() > 0 && out_ready) q.delete(0);
        if (acc) begin
            e.ctrl = in_ctrl; e.pc = in_pc; e.imm = in_imm;
            e.a = in_src_addr; e.d = in_src_data; e.dst = in_dst_addr;
            q.push_back(e);
        end
        foreach (q[k])
            for (int i = 0; i < 2; i++)
                q[k].d[i] = fwd(q[k].a[i], q[k].d[i]);
    endfunction

    task automatic check_out();
        chk("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("out_pc", out_pc, q[0].pc);
            chk("out_ctrl", out_ctrl, q[0].ctrl);
            chk("out_imm", out_imm, q[0].imm);
            chk("out_src_addr", out_src_addr, q[0].a);
            chk("out_src_data", out_src_data, q[0].d);
            chk("out_dst_addr", out_dst_addr, q[0].dst);
        end else begin
            chk("idle_ctrl", out_ctrl, 0);
            chk("idle_dst", out_dst_addr, 0);
        end
    endtask

    // Inputs are driven at negedge; one call covers one clock of the stage.
    task automatic cycle();
        #1;
        chk("in_ready", in_ready, (q.size() < 2) && !bubble);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_out();
    endtask

    task automatic set_in(input logic v, input logic [31:0] pc, input logic [4:0] a0, input logic [4:0] a1,
                          input logic [31:0] d0, input logic [31:0] d1);
        in_valid    = v;
        in_pc       = pc;
        in_src_addr = {a1, a0};
        in_src_data = {d1, d0};
        in_ctrl     = 16'($urandom);
        in_imm      = $urandom;
        in_dst_addr = 5'($urandom);
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        bubble    = 1'b0;
        flush     = 1'b0;
        fwd_valid = 2'b00;
        out_ready = 1'b1;
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        fwd_addr = '0;
        fwd_data = '0;
        idle();
        set_in(1'b0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0);
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_ctrl", out_ctrl, 0);
        chk("rst_dst", out_dst_addr, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_ready", in_ready, 1);
        bubble = 1'b1;
        #1;
        chk("rst_ready_bubble", in_ready, 0);
        bubble = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single accept
        set_in(1'b1, 32'h100, 5'd1, 5'd2, 32'd5, 32'd7);
        cycle();
        chk("single_pc", out_pc, 32'h100);
        chk("single_data", out_src_data, {32'd7, 32'd5});
        idle(); cycle();

        // Priority forwarding and zero-register exemption
        set_in(1'b1, 32'h200, 5'd3, 5'd4, 32'h11, 32'h22);
        fwd_valid = 2'b11; fwd_addr = {5'd3, 5'd3}; fwd_data = {32'hBB, 32'hAA};
        cycle();
        chk("prio_fwd", out_src_data[31:0], 32'hAA);
        set_in(1'b1, 32'h204, 5'd0, 5'd4, 32'h33, 32'h22);
        fwd_addr = {5'd0, 5'd0};
        cycle();
        chk("zero_reg", out_src_data[31:0], 32'h33);
        idle(); cycle();

        // Backpressure and skid
        out_ready = 1'b0;
        set_in(1'b1, 32'hA00, 5'd1, 5'd2, 32'h1, 32'h2);
        cycle();
        set_in(1'b1, 32'hB00, 5'd3, 5'd4, 32'h3, 32'h4);
        cycle();
        #1;
        chk("skid_full", in_ready, 0);
        chk("a_held", out_pc, 32'hA00);
        out_ready = 1'b1;
        set_in(1'b1, 32'hC00, 5'd5, 5'd6, 32'h5, 32'h6);
        cycle();
        chk("b_follows", out_pc, 32'hB00);
        cycle();
        chk("c_follows", out_pc, 32'hC00);
        idle(); cycle();

        // Held-entry refresh
        out_ready = 1'b0;
        set_in(1'b1, 32'hD00, 5'd2, 5'd9, 32'h1, 32'h2);
        cycle();
        in_valid = 1'b0;
        fwd_valid = 2'b10; fwd_addr = {5'd9, 5'd0}; fwd_data = {32'h55, 32'h0};
        cycle();
        fwd_valid = 2'b00;
        cycle();
        chk("refresh", out_src_data[63:32], 32'h55);
        idle(); cycle();

        // Bubble
        bubble = 1'b1;
        set_in(1'b1, 32'hE00, 5'd1, 5'd1, 32'h9, 32'h9);
        cycle(); cycle();
        chk("bubble_valid", out_valid, 0);
        chk("bubble_ctrl", out_ctrl, 0);
        chk("bubble_dst", out_dst_addr, 0);
        bubble = 1'b0;

        // Flush with both slots full and a live input
        out_ready = 1'b0;
        set_in(1'b1, 32'hF00, 5'd1, 5'd2, 32'h1, 32'h2); cycle();
        set_in(1'b1, 32'hF04, 5'd1, 5'd2, 32'h1, 32'h2); cycle();
        flush = 1'b1;
        set_in(1'b1, 32'hF08, 5'd1, 5'd2, 32'h1, 32'h2); cycle();
        chk("flush_valid", out_valid, 0);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush_skid_empty", in_ready, 1);
        idle(); cycle();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            set_in(1'($urandom), $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   $urandom, $urandom);
            out_ready = ($urandom % 4) != 0;
            bubble    = ($urandom % 8) == 0;
            flush     = ($urandom % 32) == 0;
            fwd_valid = 2'($urandom);
            fwd_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            fwd_data  = {$urandom, $urandom};
            cycle();
        end

        // Async reset mid-stream
        idle();
        set_in(1'b1, 32'h1234, 5'd1, 5'd2, 32'h1, 32'h2);
        cycle();
        chk("pre_arst_valid", out_valid, 1);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_ctrl", out_ctrl, 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(); cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
